// File: rtl/demux_1to4_buffered.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_buffered
// Brief    : 1-to-4 word demultiplexer. One valid/ready producer port routes
//            each word to one of four consumer channels chosen by in_sel.
//            Every channel has its own 2-entry FIFO, so a stalled consumer
//            only back-pressures words addressed to its own channel.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to4_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  // Occupancy threshold at which a channel stops accepting new words.
  localparam logic [1:0] C_FULL = 2'(DEPTH);

  logic [1:0]       w_cnt  [4];
  logic [WIDTH-1:0] w_head [4];
  logic [3:0]       w_push;
  logic [3:0]       w_pop;

  // Per-channel pop strobes, ready toward the selected channel, and the
  // one-hot push strobe. A full channel still accepts when it pops this cycle.
  always_comb begin
    w_pop    = out_valid & out_ready;
    in_ready = !rst && ((w_cnt[in_sel] < C_FULL) || w_pop[in_sel]);
    w_push   = 4'b0000;
    if (in_valid && in_ready) begin
      w_push = 4'b0001 << in_sel;
    end
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_ch
      logic [WIDTH-1:0] r_mem [2];
      logic             r_wptr;
      logic             r_rptr;
      logic [1:0]       r_cnt;

      // Channel FIFO: storage, 1-bit wrapping pointers and occupancy count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem[0] <= '0;
          r_mem[1] <= '0;
          r_wptr   <= 1'b0;
          r_rptr   <= 1'b0;
          r_cnt    <= 2'd0;
        end else begin
          if (w_push[g]) begin
            r_mem[r_wptr] <= in_data;
            r_wptr        <= ~r_wptr;
          end
          if (w_pop[g]) begin
            r_rptr <= ~r_rptr;
          end
          case ({w_push[g], w_pop[g]})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      assign w_cnt[g]     = r_cnt;
      assign w_head[g]    = r_mem[r_rptr];
      assign out_valid[g] = (r_cnt != 2'd0);
    end
  endgenerate

  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to4_buffered
// Brief    : Self-checking bench for demux_1to4_buffered: directed vector
//            table, reset sequence and a random scoreboarded stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_buffered;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1to4_buffered #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [1:0]  sel;
    logic        vld;
    logic [3:0]  ordy;
    logic        exp_rdy;   // in_ready before the edge
    logic [3:0]  exp_ov;    // out_valid after the edge
    int          chk;       // channel whose data is checked after the edge, 4 = none
    logic [31:0] exp_dat;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int ch);
    case (ch)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  initial begin
    // Route by select
    tbl[0]  = '{32'h0,        2'd0, 1'b1, 4'hF, 1'b1, 4'b0001, 0, 32'h0};
    tbl[1]  = '{32'h1,        2'd1, 1'b1, 4'hF, 1'b1, 4'b0010, 1, 32'h1};
    tbl[2]  = '{32'h2,        2'd2, 1'b1, 4'hF, 1'b1, 4'b0100, 2, 32'h2};
    tbl[3]  = '{32'h3,        2'd3, 1'b1, 4'hF, 1'b1, 4'b1000, 3, 32'h3};
    tbl[4]  = '{32'h0,        2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 4, 32'h0};
    // Fill and stall ch2
    tbl[5]  = '{32'hA0000001, 2'd2, 1'b1, 4'h0, 1'b1, 4'b0100, 2, 32'hA0000001};
    tbl[6]  = '{32'hA0000002, 2'd2, 1'b1, 4'h0, 1'b1, 4'b0100, 2, 32'hA0000001};
    tbl[7]  = '{32'h0,        2'd2, 1'b0, 4'h0, 1'b0, 4'b0100, 2, 32'hA0000001};
    tbl[8]  = '{32'h0,        2'd1, 1'b0, 4'h0, 1'b1, 4'b0100, 2, 32'hA0000001};
    tbl[9]  = '{32'h0,        2'd1, 1'b0, 4'h4, 1'b1, 4'b0100, 2, 32'hA0000002};
    tbl[10] = '{32'h0,        2'd1, 1'b0, 4'h4, 1'b1, 4'b0000, 4, 32'h0};
    // Push+pop at full on ch1
    tbl[11] = '{32'h11,       2'd1, 1'b1, 4'h0, 1'b1, 4'b0010, 1, 32'h11};
    tbl[12] = '{32'h22,       2'd1, 1'b1, 4'h0, 1'b1, 4'b0010, 1, 32'h11};
    tbl[13] = '{32'h33,       2'd1, 1'b1, 4'h0, 1'b0, 4'b0010, 1, 32'h11};
    tbl[14] = '{32'h33,       2'd1, 1'b1, 4'h2, 1'b1, 4'b0010, 1, 32'h22};
    tbl[15] = '{32'h0,        2'd1, 1'b0, 4'h0, 1'b0, 4'b0010, 1, 32'h22};
    tbl[16] = '{32'h0,        2'd0, 1'b0, 4'h2, 1'b1, 4'b0010, 1, 32'h33};
    tbl[17] = '{32'h0,        2'd0, 1'b0, 4'h2, 1'b1, 4'b0000, 4, 32'h0};
    // Channel isolation: ch0 full, ch3 still accepts
    tbl[18] = '{32'hC0,       2'd0, 1'b1, 4'h0, 1'b1, 4'b0001, 0, 32'hC0};
    tbl[19] = '{32'hC1,       2'd0, 1'b1, 4'h0, 1'b1, 4'b0001, 0, 32'hC0};
    tbl[20] = '{32'h0,        2'd0, 1'b0, 4'h0, 1'b0, 4'b0001, 0, 32'hC0};
    tbl[21] = '{32'h55,       2'd3, 1'b1, 4'h0, 1'b1, 4'b1001, 3, 32'h55};
    tbl[22] = '{32'h0,        2'd0, 1'b0, 4'h0, 1'b0, 4'b1001, 0, 32'hC0};
    tbl[23] = '{32'h56,       2'd3, 1'b1, 4'h0, 1'b1, 4'b1001, 3, 32'h55};
  end

  // Random-stream scoreboard state
  logic [31:0] q [4][$];

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_in_ready",  32'(in_ready),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_data = tbl[i].din; in_sel = tbl[i].sel;
      in_valid = tbl[i].vld; out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      if (tbl[i].chk < 4)
        check($sformatf("v%0d_out_data%0d", i, tbl[i].chk), dat(tbl[i].chk), tbl[i].exp_dat);
    end

    // Reset mid-operation: ch0 and ch3 hold two words each
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hDEAD; out_ready = 4'h0; rst = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'h0);
    check("rst_mid_out_data0", out_data0, 32'h0);
    check("rst_mid_out_data3", out_data3, 32'h0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
    @(posedge clk);
    #1;
    check("empty_ready_ignored", 32'(out_valid), 32'h0);
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h77; out_ready = 4'h0;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 32'(out_valid), 32'h1);
    check("post_rst_out_data0", out_data0, 32'h77);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'h1;
    @(posedge clk);
    #1;
    check("post_rst_drain", 32'(out_valid), 32'h0);

    // Random stream with per-channel scoreboard
    begin
      int accepted = 0;
      int cycles   = 0;
      bit holding  = 0;
      while ((accepted < 64 || q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0)
             && cycles < 2000) begin
        @(negedge clk);
        cycles++;
        if (!holding) begin
          in_data  = $urandom;
          in_sel   = 2'($urandom_range(0, 3));
          in_valid = (accepted < 64) && ($urandom_range(0, 3) != 0);
        end
        out_ready = 4'($urandom);
        #1;
        for (int n = 0; n < 4; n++) begin
          check($sformatf("rnd_out_valid%0d", n), 32'(out_valid[n]), 32'(q[n].size() != 0));
        end
        check("rnd_in_ready", 32'(in_ready),
              32'((q[in_sel].size() < 2) || (q[in_sel].size() != 0 && out_ready[in_sel])));
        for (int n = 0; n < 4; n++) begin
          if (out_ready[n] && q[n].size() != 0) begin
            check($sformatf("rnd_out_data%0d", n), dat(n), q[n][0]);
            void'(q[n].pop_front());
          end
        end
        if (in_valid && in_ready) begin
          q[in_sel].push_back(in_data);
          accepted++;
          holding = 0;
        end else begin
          holding = in_valid;
        end
        @(posedge clk);
      end
      if (cycles >= 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_timeout: got %0d accepted expected 64 and drained", accepted);
      end
    end

    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'h0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_1to4_buffered.md
Name: demux_1to4_buffered

Overview:
- 32-bit 1-to-4 demultiplexer: the distribution counterpart of the team's 4-to-1 word mux.
- Accepts one word per cycle on a valid/ready input port and routes it to one of four output channels, chosen by a 2-bit select.
- Each channel has a 2-entry FIFO, so a stalled consumer does not block words bound for other channels once they are accepted.
- Sits between a single producer and four independent consumers in the datapath.

Parameters:
- WIDTH, 32, data word width in bits (all data ports).
- DEPTH, 2, entries per channel FIFO. Fixed at 2 for this release; other values are unsupported.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination channel: 0=ch0, 1=ch1, 2=ch2, 3=ch3.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts the offered word this cycle (combinational).
- out_data0  output  WIDTH  head word of ch0 FIFO.
- out_data1  output  WIDTH  head word of ch1 FIFO.
- out_data2  output  WIDTH  head word of ch2 FIFO.
- out_data3  output  WIDTH  head word of ch3 FIFO.
- out_valid  output  4  bit N set: channel N holds at least one word.
- out_ready  input  4  bit N set: consumer N takes the head word this cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All FIFO counts and pointers go to 0; out_valid=4'b0000; all FIFO storage cleared, so out_dataN=0.
  - in_ready is forced to 0 while rst=1.
  - Reset mid-operation discards all buffered words. No partial state survives.
- Push:
  - Occurs when in_valid && in_ready at a clk edge.
  - The word is written to the tail of FIFO[in_sel].
  - in_ready = !rst && (count[in_sel] < 2 || (out_valid[in_sel] && out_ready[in_sel])).
  - in_ready depends only on the selected channel; other channels being full has no effect.
- Pop:
  - Occurs when out_valid[N] && out_ready[N] at a clk edge; the head pointer of FIFO N advances.
  - All four channels may pop in the same cycle.
- Latency:
  - A word pushed at edge k appears on out_dataN with out_valid[N]=1 immediately after edge k (1 cycle).
  - There is no combinational path from in_data to out_dataN.
- Ordering: strict FIFO order within each channel. No ordering guarantee across channels.
- Per-channel count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. Allowed at count 1 and count 2 (full).
  - Push and pop together at count 0 is impossible, because out_valid=0.
- Boundaries:
  - Full channel (count 2) with out_ready=0: in_ready=0 for that select. The producer must hold in_data/in_sel stable until accepted.
  - Empty channel: out_valid[N]=0. out_dataN is don't-care but X-free; the bench must not check it.
  - out_ready[N]=1 with out_valid[N]=0: ignored, no state change.
  - in_valid=0: no push. in_ready still reflects the channel addressed by in_sel.
  - Pointers are 1 bit each and wrap modulo 2. The count is 2 bits, range 0..2.
- Consumer contract: out_dataN is stable while out_valid[N]=1 and out_ready[N]=0.

Test Plan:
1. Route by select: after reset, push in_data=0,1,2,3 with in_sel=0,1,2,3 on consecutive cycles, out_ready=4'b1111 -> each word appears on out_data{sel} one cycle after its push, with out_valid one-hot for one cycle; out_data{sel}[1:0]==sel.
2. Fill and stall: out_ready=0, push 0xA0000001 then 0xA0000002 to ch2 -> out_valid[2]=1, out_data2=0xA0000001, in_ready=0 with in_sel=2 and 1 with in_sel=1; set out_ready[2]=1 -> 0xA0000001 then 0xA0000002 drain in order.
3. Push+pop at full: ch1 full (0x11, 0x22), out_ready[1]=1, push 0x33 to ch1 in the same cycle -> accepted; count stays 2; the sequence drained is 0x11, 0x22, 0x33.
4. Channel isolation: ch0 full with out_ready[0]=0; push 0x55 to ch3 -> accepted; out_data3=0x55 next cycle; ch0 contents unchanged.
5. Reset mid-operation: ch0 and ch3 each hold 2 words; assert rst for 1 cycle -> out_valid=0, in_ready=0 during rst; after release, a push of 0x77 to ch0 is the first word seen on out_data0.
6. Back-to-back stream: 64 random words with random in_sel and random out_ready -> the scoreboard sees per-channel order preserved, with no loss and no duplication.
